demux_pack: RTL and testbench

DEMUX_PACK -- requirements
Module: demux_pack

---
 rtl/demux_pack_pkg.sv | 20 ++
 rtl/demux_pack_lane_dec.sv | 24 ++
 rtl/demux_pack.sv | 117 +++++++++++
 tb/tb_demux_pack.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pack_pkg.sv
// demux_pack_pkg
//   Shared definitions for the demux_pack slice:
//     state_t : FILL (collecting words) / HOLD (frame presented) encodings
//     clog2   : ceiling log2, used to size the lane index
package demux_pack_pkg;

   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } state_t;

   // Smallest r with 2**r >= n; elaboration-time helper for SEL_WIDTH.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/demux_pack_lane_dec.sv
// lane_dec
//   Turns a lane index plus enable into a one-hot lane write-enable vector.
//   Ports:
//     sel    in  SEL_WIDTH  lane index
//     en     in  1          write enable
//     onehot out DEPTH      bit j set when en and sel == j
module lane_dec #(
   parameter int DEPTH     = 8,
   parameter int SEL_WIDTH = 3
) (
   input  logic [SEL_WIDTH-1:0] sel,
   input  logic                 en,
   output logic [DEPTH-1:0]     onehot
);

   always_comb begin
      // NOTE: default-assign every always_comb output first so no path leaves it unassigned (no latch).
      onehot = '0;
      for (int j = 0; j < DEPTH; j++) begin
         if (en && (sel == SEL_WIDTH'(j))) onehot[j] = 1'b1;
      end
   end

endmodule

// File: rtl/demux_pack.sv
// demux_pack
//   Packs a stream of BIT_WIDTH words into DEPTH-lane frames with
//   valid/ready handshakes on both sides. A frame is presented once its
//   last lane is written; handoff and the first word of the next frame
//   may happen in the same cycle.
//   Optional feature: define DEMUX_PACK_FLUSH_EN to add the flush input
//   (close a partial frame early) and the laneMask output (lanes written).
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset
//     dataIn       incoming word            inValid / inReady  input handshake
//     dataOut      packed frame (lane j at [BIT_WIDTH*j +: BIT_WIDTH])
//     outValid / outReady  output handshake
//     laneSel      lane the next accepted word is written to
//     flush, laneMask      only with DEMUX_PACK_FLUSH_EN
module demux_pack
   import demux_pack_pkg::*;
#(
   parameter int BIT_WIDTH = 8,
   parameter int DEPTH     = 8,
   parameter int SEL_WIDTH = clog2(DEPTH)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [BIT_WIDTH-1:0]       dataIn,
   input  logic                       inValid,
   output logic                       inReady,
`ifdef DEMUX_PACK_FLUSH_EN
   input  logic                       flush,
   output logic [DEPTH-1:0]           laneMask,
`endif
   output logic [BIT_WIDTH*DEPTH-1:0] dataOut,
   output logic                       outValid,
   input  logic                       outReady,
   output logic [SEL_WIDTH-1:0]       laneSel
);

   state_t                             state_q;
   logic [SEL_WIDTH-1:0]               sel_q;
   logic [DEPTH-1:0][BIT_WIDTH-1:0]    lanes_q;
   logic [DEPTH-1:0]                   we;
   logic [SEL_WIDTH-1:0]               wr_sel;
   logic                               in_xfer;
   logic                               out_xfer;
   logic                               last_lane;
   logic                               flush_req;

`ifdef DEMUX_PACK_FLUSH_EN
   assign flush_req = flush;
`else
   assign flush_req = 1'b0;
`endif

   assign outValid  = (state_q == HOLD);
   // While holding, a new word can enter only in the cycle the frame leaves.
   assign inReady   = (state_q == FILL) ? 1'b1 : outReady;
   assign in_xfer   = inValid && inReady;
   assign out_xfer  = outValid && outReady;
   assign last_lane = (sel_q == SEL_WIDTH'(DEPTH - 1));

   // An input accepted during HOLD starts the next frame at lane 0.
   assign wr_sel = (state_q == HOLD) ? '0 : sel_q;

   lane_dec #(
      .DEPTH     (DEPTH),
      .SEL_WIDTH (SEL_WIDTH)
   ) u_lane_dec (
      .sel    (wr_sel),
      .en     (in_xfer),
      .onehot (we)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
         state_q <= FILL;
         sel_q   <= '0;
         // NOTE: the lane storage is reset because unwritten lanes must read as zero.
         lanes_q <= '0;
      end else if (out_xfer) begin
         // Handoff: clear the frame, optionally taking the next word into lane 0.
         state_q <= FILL;
         sel_q   <= in_xfer ? SEL_WIDTH'(1) : '0;
         for (int j = 0; j < DEPTH; j++) begin
            lanes_q[j] <= we[j] ? dataIn : '0;
         end
      end else if (state_q == FILL) begin
         for (int j = 0; j < DEPTH; j++) begin
            if (we[j]) lanes_q[j] <= dataIn;
         end
         if (in_xfer) begin
            // On a flush close, sel_q ends up holding the written-lane count.
            sel_q <= last_lane ? '0 : sel_q + SEL_WIDTH'(1);
            if (last_lane || flush_req) state_q <= HOLD;
         end else if (flush_req && (sel_q != '0)) begin
            state_q <= HOLD;
         end
      end
   end

`ifdef DEMUX_PACK_FLUSH_EN
   logic [DEPTH-1:0] mask_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mask_q <= '0;
      end else begin
         mask_q <= out_xfer ? we : (mask_q | we);
      end
   end

   assign laneMask = mask_q;
`endif

   assign dataOut = lanes_q;
   assign laneSel = sel_q;

endmodule

// File: tb/tb_demux_pack.sv
// tb_demux_pack
//   Directed bench for demux_pack: a DEPTH=4 and a DEPTH=3 instance
//   (BIT_WIDTH=8), plus a randomised handshake run against a small
//   frame model on the DEPTH=4 instance. Flush/laneMask steps are
//   compiled only with DEMUX_PACK_FLUSH_EN.
module tb_demux_pack;

   logic        clk;
   logic        rst_n;

   // DEPTH=4 instance
   logic [7:0]  d4;
   logic        v4;
   logic        r4;
   logic [31:0] d4_out;
   logic        v4_out;
   logic        or4;
   logic [1:0]  ls4;

   // DEPTH=3 instance
   logic [7:0]  d3;
   logic        v3;
   logic        r3;
   logic [23:0] d3_out;
   logic        v3_out;
   logic        or3;
   logic [1:0]  ls3;

`ifdef DEMUX_PACK_FLUSH_EN
   logic        fl4;
   logic [3:0]  m4;
   logic        fl3;
   logic [2:0]  m3;
`endif

   int n_checks;
   int n_fail;

   demux_pack #(.BIT_WIDTH(8), .DEPTH(4)) u4 (
      .clk      (clk),
      .rst_n    (rst_n),
      .dataIn   (d4),
      .inValid  (v4),
      .inReady  (r4),
`ifdef DEMUX_PACK_FLUSH_EN
      .flush    (fl4),
      .laneMask (m4),
`endif
      .dataOut  (d4_out),
      .outValid (v4_out),
      .outReady (or4),
      .laneSel  (ls4)
   );

   demux_pack #(.BIT_WIDTH(8), .DEPTH(3)) u3 (
      .clk      (clk),
      .rst_n    (rst_n),
      .dataIn   (d3),
      .inValid  (v3),
      .inReady  (r3),
`ifdef DEMUX_PACK_FLUSH_EN
      .flush    (fl3),
      .laneMask (m3),
`endif
      .dataOut  (d3_out),
      .outValid (v3_out),
      .outReady (or3),
      .laneSel  (ls3)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are read there too.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send4(input logic [7:0] w);
      v4 = 1'b1;
      d4 = w;
      tick();
      v4 = 1'b0;
   endtask

   task automatic send3(input logic [7:0] w);
      v3 = 1'b1;
      d3 = w;
      tick();
      v3 = 1'b0;
   endtask

   function automatic logic [7:0] word(input int k);
      return 8'(k * 37 + 5);
   endfunction

   initial begin
      logic [31:0] exp_frame;
      bit          full;
      bit          exp_ir;
      bit          in_x;
      bit          out_x;
      int          cnt;
      int          tx;
      int          rx;
      int          cyc;

      n_checks = 0;
      n_fail   = 0;
      rst_n = 1'b0;
      d4 = '0; v4 = 1'b0; or4 = 1'b0;
      d3 = '0; v3 = 1'b0; or3 = 1'b0;
`ifdef DEMUX_PACK_FLUSH_EN
      fl4 = 1'b0; fl3 = 1'b0;
`endif

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_outvalid", v4_out, 1'b0);
      check("rst_dataout", d4_out, 32'h0);
      check("rst_lanesel", ls4, 2'd0);
      check("rst_inready", r4, 1'b1);
`ifdef DEMUX_PACK_FLUSH_EN
      check("rst_lanemask", m4, 4'b0000);
`endif
      rst_n = 1'b1;
      tick();

      // Full frame with consumer stalled
      send4(8'h11);
      check("fill_lanesel1", ls4, 2'd1);
      check("fill_outvalid0", v4_out, 1'b0);
      send4(8'h22);
      check("partial_zero_lanes", d4_out, 32'h0000_2211);
      send4(8'h33);
      send4(8'h44);
      check("frame_outvalid", v4_out, 1'b1);
      check("frame_data", d4_out, 32'h4433_2211);
      check("frame_inready0", r4, 1'b0);
      check("frame_lanesel_wrap", ls4, 2'd0);
`ifdef DEMUX_PACK_FLUSH_EN
      check("frame_mask_full", m4, 4'b1111);
`endif

      // Hold indefinitely while stalled; offered input is ignored
      v4 = 1'b1;
      d4 = 8'h99;
      repeat (3) tick();
      check("stall_outvalid", v4_out, 1'b1);
      check("stall_data", d4_out, 32'h4433_2211);
      check("stall_lanesel", ls4, 2'd0);

      // Handoff with a simultaneous input word
      d4  = 8'h55;
      or4 = 1'b1;
      #1;
      check("hold_inready_follows", r4, 1'b1);
      tick();
      v4  = 1'b0;
      or4 = 1'b0;
      check("handoff_outvalid", v4_out, 1'b0);
      check("handoff_data", d4_out, 32'h0000_0055);
      check("handoff_lanesel", ls4, 2'd1);
`ifdef DEMUX_PACK_FLUSH_EN
      check("handoff_mask", m4, 4'b0001);
`endif

      // Complete that frame, then hand off with no input
      send4(8'h66);
      send4(8'h77);
      send4(8'h88);
      check("frame2_data", d4_out, 32'h8877_6655);
      check("frame2_outvalid", v4_out, 1'b1);
      or4 = 1'b1;
      tick();
      or4 = 1'b0;
      check("drain_data", d4_out, 32'h0);
      check("drain_lanesel", ls4, 2'd0);
      check("drain_outvalid", v4_out, 1'b0);

      // Reset mid-frame discards the partial frame
      send4(8'hAA);
      send4(8'hBB);
      rst_n = 1'b0;
      #1;
      check("midrst_outvalid", v4_out, 1'b0);
      check("midrst_data", d4_out, 32'h0);
      check("midrst_lanesel", ls4, 2'd0);
      tick();
      rst_n = 1'b1;
      tick();
      send4(8'h01);
      send4(8'h02);
      send4(8'h03);
      send4(8'h04);
      check("postrst_frame", d4_out, 32'h0403_0201);
      check("postrst_outvalid", v4_out, 1'b1);

      // Reset during HOLD discards the presented frame
      rst_n = 1'b0;
      #1;
      check("holdrst_outvalid", v4_out, 1'b0);
      check("holdrst_data", d4_out, 32'h0);
      tick();
      rst_n = 1'b1;
      tick();

`ifdef DEMUX_PACK_FLUSH_EN
      // Flush a two-word partial frame
      send4(8'h01);
      send4(8'h02);
      fl4 = 1'b1;
      tick();
      fl4 = 1'b0;
      check("flush_outvalid", v4_out, 1'b1);
      check("flush_data", d4_out, 32'h0000_0201);
      check("flush_mask", m4, 4'b0011);
      check("flush_count", ls4, 2'd2);
      // Flush while holding is ignored
      fl4 = 1'b1;
      tick();
      fl4 = 1'b0;
      check("flush_hold_ignored", d4_out, 32'h0000_0201);
      or4 = 1'b1;
      tick();
      or4 = 1'b0;
      check("flush_handoff_mask", m4, 4'b0000);
      check("flush_handoff_outvalid", v4_out, 1'b0);
      // Flush on an empty frame is ignored
      fl4 = 1'b1;
      tick();
      fl4 = 1'b0;
      tick();
      check("flush_empty_ignored", v4_out, 1'b0);
      // Flush together with a word closes after that word
      fl4 = 1'b1;
      send4(8'h03);
      fl4 = 1'b0;
      check("flush_word_outvalid", v4_out, 1'b1);
      check("flush_word_data", d4_out, 32'h0000_0003);
      check("flush_word_mask", m4, 4'b0001);
      or4 = 1'b1;
      tick();
      or4 = 1'b0;
`endif

      // DEPTH=3: two frames back to back, consumer always ready
      or3 = 1'b1;
      for (int r = 0; r < 2; r++) begin
         send3(8'hA1);
         check("d3_lanesel1", ls3, 2'd1);
         if (r == 1) begin
            check("d3_handoff_outvalid", v3_out, 1'b0);
            check("d3_handoff_data", d3_out, 24'h00_00A1);
         end
         send3(8'hB2);
         check("d3_lanesel2", ls3, 2'd2);
         send3(8'hC3);
         check("d3_wrap", ls3, 2'd0);
         check("d3_outvalid", v3_out, 1'b1);
         check("d3_frame", d3_out, 24'hC3_B2A1);
      end
      tick();
      check("d3_drained", v3_out, 1'b0);
      or3 = 1'b0;

      // Random stalls on both sides: 1000 words against a frame model
      full = 1'b0;
      cnt  = 0;
      tx   = 0;
      rx   = 0;
      cyc  = 0;
      while (rx < 1000 && cyc < 20000) begin
         v4  = (tx < 1000) && ($urandom_range(0, 3) != 0);
         d4  = word(tx);
         or4 = ($urandom_range(0, 2) != 0);
         #1;
         exp_ir = full ? or4 : 1'b1;
         check("rnd_inready", r4, exp_ir);
         check("rnd_outvalid", v4_out, full);
         in_x  = v4 && exp_ir;
         out_x = full && or4;
         if (out_x) begin
            for (int l = 0; l < 4; l++) exp_frame[8*l +: 8] = word(rx + l);
            check("rnd_frame", d4_out, exp_frame);
            rx   = rx + 4;
            full = 1'b0;
            cnt  = 0;
         end
         if (in_x) begin
            tx++;
            cnt++;
            if (cnt == 4) begin
               full = 1'b1;
               cnt  = 0;
            end
         end
         tick();
         cyc++;
      end
      v4  = 1'b0;
      or4 = 1'b0;
      check("rnd_words_sent", tx, 1000);
      check("rnd_words_received", rx, 1000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
